// File: rtl/regs_wb_pkg.sv
// Shared constants, types and FSM encodings for the regs_wb register file
// and its debug access arbiter.
package regs_wb_pkg;

    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Same-cycle forwarding hit: a core write lands on the address being read.
    function automatic logic fwd_hit(input logic wen, input reg_addr_t waddr,
                                     input reg_addr_t raddr);
        return wen && (waddr == raddr) && (raddr != ZERO_REG);
    endfunction

endpackage

// File: rtl/regs_dbg_arb.sv
// Debug access arbiter: four-phase handshake FSM, starvation counter and
// pipeline hold request. Core write-back always wins a conflicting cycle.
module regs_dbg_arb
    import regs_wb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      dbg_req,
    input  logic      dbg_we,
    input  logic      conflict,
    input  reg_data_t rd_value,
    output logic      dbg_wr_en,
    output logic      dbg_ack,
    output reg_data_t dbg_rdata,
    output logic      hold_req
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0] state;
    logic [3:0] starve_cnt;

    // NOTE: outputs decoded in always_comb get a default first so no latch is inferred.
    always_comb begin
        dbg_wr_en = 1'b0;
        case (state)
            ST_IDLE: dbg_wr_en = dbg_req && dbg_we && !conflict;
            ST_WAIT: dbg_wr_en = !conflict;
            default: dbg_wr_en = 1'b0;
        endcase
    end

    assign dbg_ack = (state == ST_ACK);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            dbg_rdata  <= '0;
            hold_req   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dbg_req) begin
                        if (!dbg_we) begin
                            dbg_rdata <= rd_value;
                            state     <= ST_ACK;
                        end else if (conflict) begin
                            starve_cnt <= 4'd1;
                            state      <= ST_WAIT;
                        end else begin
                            state <= ST_ACK;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!conflict) begin
                        starve_cnt <= '0;
                        hold_req   <= 1'b0;
                        state      <= ST_ACK;
                    end else begin
                        if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 4'd1;
                        // Hold follows the counter by one cycle, so it is a clean register output.
                        if (starve_cnt == LIMIT) hold_req <= 1'b1;
                    end
                end
                ST_ACK:  state <= ST_DONE;
                ST_DONE: if (!dbg_req) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/regs_wb.sv
// Integer register file with two combinational read ports, core write-back and
// an arbitrated debug port. Optional same-cycle forwarding: define REGS_BYPASS_EN.
module regs_wb
    import regs_wb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_wen_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_data_i,
    input  logic [4:0]  rs1_addr_i,
    output logic [31:0] rs1_data_o,
    input  logic [4:0]  rs2_addr_i,
    output logic [31:0] rs2_data_o,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [4:0]  dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_rdata_o,
    output logic        hold_req_o
);

    reg_data_t regs [REG_NUM];

    logic      core_wr;
    logic      dbg_conflict;
    logic      dbg_wr_en;
    reg_data_t rs1_arr;
    reg_data_t rs2_arr;
    reg_data_t dbg_arr;
    reg_data_t dbg_rd_value;

    assign core_wr = reg_wen_i && (rd_addr_i != ZERO_REG);
    // A debug write to x0 is discarded anyway, so it never has to wait.
    assign dbg_conflict = core_wr && (dbg_addr_i != ZERO_REG);

    // NOTE: the array is explicitly reset because every entry must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (core_wr) begin
            regs[rd_addr_i] <= rd_data_i;
        end else if (dbg_wr_en && (dbg_addr_i != ZERO_REG)) begin
            regs[dbg_addr_i] <= dbg_wdata_i;
        end
    end

    assign rs1_arr = (rs1_addr_i == ZERO_REG) ? '0 : regs[rs1_addr_i];
    assign rs2_arr = (rs2_addr_i == ZERO_REG) ? '0 : regs[rs2_addr_i];
    assign dbg_arr = (dbg_addr_i == ZERO_REG) ? '0 : regs[dbg_addr_i];

`ifdef REGS_BYPASS_EN
    assign rs1_data_o   = fwd_hit(reg_wen_i, rd_addr_i, rs1_addr_i) ? rd_data_i : rs1_arr;
    assign rs2_data_o   = fwd_hit(reg_wen_i, rd_addr_i, rs2_addr_i) ? rd_data_i : rs2_arr;
    assign dbg_rd_value = fwd_hit(reg_wen_i, rd_addr_i, dbg_addr_i) ? rd_data_i : dbg_arr;
`else
    assign rs1_data_o   = rs1_arr;
    assign rs2_data_o   = rs2_arr;
    assign dbg_rd_value = dbg_arr;
`endif

    regs_dbg_arb #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_dbg_arb (
        .clk      (clk),
        .rst      (rst),
        .dbg_req  (dbg_req_i),
        .dbg_we   (dbg_we_i),
        .conflict (dbg_conflict),
        .rd_value (dbg_rd_value),
        .dbg_wr_en(dbg_wr_en),
        .dbg_ack  (dbg_ack_o),
        .dbg_rdata(dbg_rdata_o),
        .hold_req (hold_req_o)
    );

endmodule

// File: tb/tb_regs_wb.sv
// Self-checking bench for regs_wb: directed scenarios plus randomized core and
// debug traffic checked against a plain array model of the register file.
module tb_regs_wb;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_wen_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic [4:0]  rs1_addr_i;
    logic [31:0] rs1_data_o;
    logic [4:0]  rs2_addr_i;
    logic [31:0] rs2_data_o;
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_ack_o;
    logic [31:0] dbg_rdata_o;
    logic        hold_req_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [32];

    regs_wb #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_wen_i  (reg_wen_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_i  (rd_data_i),
        .rs1_addr_i (rs1_addr_i),
        .rs1_data_o (rs1_data_o),
        .rs2_addr_i (rs2_addr_i),
        .rs2_data_o (rs2_data_o),
        .dbg_req_i  (dbg_req_i),
        .dbg_we_i   (dbg_we_i),
        .dbg_addr_i (dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i),
        .dbg_ack_o  (dbg_ack_o),
        .dbg_rdata_o(dbg_rdata_o),
        .hold_req_o (hold_req_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected read-port value given the model and the current core write inputs.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef REGS_BYPASS_EN
        if (reg_wen_i && rd_addr_i == a) return rd_data_i;
`endif
        return model[a];
    endfunction

    // Advance one clock, applying the core write (or reset) to the model.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (reg_wen_i && rd_addr_i != 5'd0) begin
            model[rd_addr_i] = rd_data_i;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_core(input int pct);
        reg_wen_i = ($urandom_range(99) < pct);
        rd_addr_i = 5'($urandom);
        rd_data_i = $urandom;
    endtask

    task automatic check_reads(input string tag);
        rs1_addr_i = 5'($urandom);
        rs2_addr_i = 5'($urandom);
        #1;
        check({tag, "_rs1"}, rs1_data_o, exp_read(rs1_addr_i));
        check({tag, "_rs2"}, rs2_data_o, exp_read(rs2_addr_i));
    endtask

    // Debug write of x7 while the core keeps writing x3 for n cycles.
    task automatic starve_x7(input int n);
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd7; dbg_wdata_i = 32'hA5A5A5A5;
        for (int k = 1; k <= n; k++) begin
            reg_wen_i = 1'b1; rd_addr_i = 5'd3; rd_data_i = $urandom;
            tick();
            check("starve_hold", 32'(hold_req_o), 32'(k > LIMIT));
            check("starve_ack", 32'(dbg_ack_o), 32'd0);
        end
    endtask

    // One full four-phase debug transaction under random core traffic.
    task automatic dbg_txn(input logic we, input logic [4:0] a, input logic [31:0] d, input int pct);
        int denied = 0;
        bit done = 1'b0;
        logic [31:0] exp_rd = 32'd0;
        dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = d;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            rand_core(cyc < 12 ? pct : 0);
            check_reads("txn");
            check("txn_ack_early", 32'(dbg_ack_o), 32'd0);
            if (we && reg_wen_i && rd_addr_i != 5'd0 && a != 5'd0) begin
                denied++;
                tick();
                check("txn_hold", 32'(hold_req_o), 32'(denied > LIMIT));
            end else begin
                exp_rd = exp_read(a);
                if (we && a != 5'd0) model[a] = d;
                tick();
                done = 1'b1;
                check("txn_ack", 32'(dbg_ack_o), 32'd1);
                check("txn_hold_clr", 32'(hold_req_o), 32'd0);
                if (!we) check("txn_rdata", dbg_rdata_o, exp_rd);
            end
        end
        check("txn_granted", 32'(done), 32'd1);
        dbg_req_i = 1'b0;
        rand_core(pct);
        tick();
        check("txn_ack_once", 32'(dbg_ack_o), 32'd0);
        if (!we) check("txn_rdata_hold", dbg_rdata_o, exp_rd);
        rand_core(pct);
        tick();
    endtask

    initial begin
        rst = 1'b1; reg_wen_i = 1'b0; rd_addr_i = '0; rd_data_i = '0;
        rs1_addr_i = '0; rs2_addr_i = '0;
        dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'hX;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ack", 32'(dbg_ack_o), 32'd0);
        check("rst_hold", 32'(hold_req_o), 32'd0);
        check("rst_rdata", dbg_rdata_o, 32'd0);
        for (int i = 0; i < 4; i++) check_reads("rst");

        // Core writes x5 and x0.
        reg_wen_i = 1'b1; rd_addr_i = 5'd5; rd_data_i = 32'hDEADBEEF;
        tick();
        rd_addr_i = 5'd0; rd_data_i = 32'h1234;
        tick();
        reg_wen_i = 1'b0;
        rs1_addr_i = 5'd5; rs2_addr_i = 5'd0;
        #1;
        check("core_x5", rs1_data_o, 32'hDEADBEEF);
        check("core_x0", rs2_data_o, 32'd0);

        // Same-cycle read of the register being written.
        reg_wen_i = 1'b1; rd_addr_i = 5'd9; rd_data_i = 32'h55; rs1_addr_i = 5'd9;
        #1;
`ifdef REGS_BYPASS_EN
        check("same_cycle_x9", rs1_data_o, 32'h55);
`else
        check("same_cycle_x9", rs1_data_o, 32'd0);
`endif
        tick();
        reg_wen_i = 1'b0;

        // Debug read of x5 with the core idle.
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd5;
        #1;
        check("dbgrd_ack_pre", 32'(dbg_ack_o), 32'd0);
        tick();
        check("dbgrd_ack", 32'(dbg_ack_o), 32'd1);
        check("dbgrd_data", dbg_rdata_o, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dbgrd_no_2nd_ack", 32'(dbg_ack_o), 32'd0);
            check("dbgrd_data_held", dbg_rdata_o, 32'hDEADBEEF);
        end
        dbg_req_i = 1'b0;
        tick();
        tick();

        // Starved debug write of x7.
        starve_x7(6);
        reg_wen_i = 1'b0;
        model[7] = 32'hA5A5A5A5;
        tick();
        check("starve_ack_after", 32'(dbg_ack_o), 32'd1);
        check("starve_hold_fall", 32'(hold_req_o), 32'd0);
        rs1_addr_i = 5'd7; rs2_addr_i = 5'd3;
        #1;
        check("starve_x7", rs1_data_o, 32'hA5A5A5A5);
        check("starve_x3", rs2_data_o, model[3]);
        tick();
        check("starve_ack_once", 32'(dbg_ack_o), 32'd0);
        dbg_req_i = 1'b0;
        tick();
        tick();

        // Random core traffic.
        for (int i = 0; i < 40; i++) begin
            rand_core(70);
            check_reads("rand_core");
            tick();
        end

        // Random debug transactions; first one is an x0 write under core load.
        dbg_txn(1'b1, 5'd0, $urandom, 100);
        for (int i = 0; i < 14; i++) begin
            dbg_txn(1'($urandom), 5'($urandom), $urandom, 60);
        end

        // Reset while starved in WAIT with hold raised.
        starve_x7(6);
        check("wait_hold_before_rst", 32'(hold_req_o), 32'd1);
        rst = 1'b1; reg_wen_i = 1'b0; dbg_req_i = 1'b0;
        tick();
        rst = 1'b0;
        check("mid_rst_hold", 32'(hold_req_o), 32'd0);
        check("mid_rst_ack", 32'(dbg_ack_o), 32'd0);
        check("mid_rst_rdata", dbg_rdata_o, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rs1_addr_i = 5'(i);
            #1;
            check("mid_rst_reg", rs1_data_o, 32'd0);
        end
        tick();
        check("post_rst_no_ack", 32'(dbg_ack_o), 32'd0);
        dbg_txn(1'b1, 5'd12, 32'hC0FFEE12, 0);
        rs1_addr_i = 5'd12;
        #1;
        check("post_rst_x12", rs1_data_o, model[12]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
